qpu_exu_wbck_arb: RTL

QPU_EXU_WBCK_ARB -- requirements
Module: QPU_exu_wbck_arb

---
 rtl/qpu_exu_wbck_arb.sv | 113 +++++++++++
 1 files changed

// File: rtl/qpu_exu_wbck_arb.sv
// Write-back arbiter: merges ALU and long-pipe results onto the classical regfile
// port with starvation protection for the ALU, plus an independent time-register path.
module qpu_exu_wbck_arb #(
  parameter int XLEN       = 32,
  parameter int RFIDX_W    = 6,
  parameter int TIME_W     = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               alu_wbck_i_valid,
  output logic               alu_wbck_i_ready,
  input  logic [RFIDX_W-1:0] alu_wbck_i_rdidx,
  input  logic [XLEN-1:0]    alu_wbck_i_wdat,
  input  logic               longp_wbck_i_valid,
  output logic               longp_wbck_i_ready,
  input  logic [RFIDX_W-1:0] longp_wbck_i_rdidx,
  input  logic [XLEN-1:0]    longp_wbck_i_wdat,
  output logic               cwbck_dest_wen,
  output logic [RFIDX_W-1:0] cwbck_dest_idx,
  output logic [XLEN-1:0]    cwbck_dest_data,
  input  logic               ntp_wbck_i_valid,
  output logic               ntp_wbck_i_ready,
  input  logic [TIME_W-1:0]  ntp_wbck_i_data,
  input  logic               tq_full,
  output logic               twbck_dest_wen,
  output logic [TIME_W-1:0]  twbck_dest_data
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0]         starve_cnt_r;
  logic [3:0]         starve_cnt_nxt_s;
  logic               starved_s;
  logic               grant_alu_s;
  logic               grant_longp_s;
  logic               alu_hsk_s;
  logic               longp_hsk_s;
  logic               cls_hsk_s;
  logic               ntp_hsk_s;
  logic [RFIDX_W-1:0] win_idx_s;
  logic [XLEN-1:0]    win_dat_s;

  // Grant selection: long pipe wins unless the ALU has waited STARVE_MAX cycles.
  always_comb begin
    grant_alu_s   = 1'b0;
    grant_longp_s = 1'b0;
    starved_s     = alu_wbck_i_valid && (starve_cnt_r == STARVE_LIM);
    if (longp_wbck_i_valid && !starved_s) begin
      grant_longp_s = 1'b1;
    end else if (alu_wbck_i_valid) begin
      grant_alu_s = 1'b1;
    end else begin
      grant_alu_s   = 1'b0;
      grant_longp_s = 1'b0;
    end
  end

  // Readies are masked by reset so nothing is accepted while the block is held.
  assign alu_wbck_i_ready   = grant_alu_s & ~rst;
  assign longp_wbck_i_ready = grant_longp_s & ~rst;
  assign ntp_wbck_i_ready   = ~tq_full & ~rst;

  assign alu_hsk_s   = alu_wbck_i_valid & alu_wbck_i_ready;
  assign longp_hsk_s = longp_wbck_i_valid & longp_wbck_i_ready;
  assign cls_hsk_s   = alu_hsk_s | longp_hsk_s;
  assign ntp_hsk_s   = ntp_wbck_i_valid & ntp_wbck_i_ready;

  // Winner payload mux and saturating starvation counter update.
  always_comb begin
    win_idx_s        = alu_wbck_i_rdidx;
    win_dat_s        = alu_wbck_i_wdat;
    starve_cnt_nxt_s = starve_cnt_r;
    if (longp_hsk_s) begin
      win_idx_s = longp_wbck_i_rdidx;
      win_dat_s = longp_wbck_i_wdat;
    end else begin
      win_idx_s = alu_wbck_i_rdidx;
      win_dat_s = alu_wbck_i_wdat;
    end
    if (!alu_wbck_i_valid || alu_hsk_s) begin
      starve_cnt_nxt_s = 4'd0;
    end else if (starve_cnt_r < STARVE_LIM) begin
      starve_cnt_nxt_s = starve_cnt_r + 4'd1;
    end else begin
      starve_cnt_nxt_s = starve_cnt_r;
    end
  end

  // Registered write-back ports; index 0 is accepted but never written.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_r    <= 4'd0;
      cwbck_dest_wen  <= 1'b0;
      cwbck_dest_idx  <= {RFIDX_W{1'b0}};
      cwbck_dest_data <= {XLEN{1'b0}};
      twbck_dest_wen  <= 1'b0;
      twbck_dest_data <= {TIME_W{1'b0}};
    end else begin
      starve_cnt_r   <= starve_cnt_nxt_s;
      cwbck_dest_wen <= cls_hsk_s && (win_idx_s != {RFIDX_W{1'b0}});
      if (cls_hsk_s) begin
        cwbck_dest_idx  <= win_idx_s;
        cwbck_dest_data <= win_dat_s;
      end
      twbck_dest_wen <= ntp_hsk_s;
      if (ntp_hsk_s) begin
        twbck_dest_data <= ntp_wbck_i_data;
      end
    end
  end

endmodule
